// File: rtl/vgaram_arbiter.sv
// Shared video/system RAM arbiter: VGA owns cycles it announced one cycle ahead,
// the CPU is granted remaining free cycles through a request/acknowledge handshake.
module vgaram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_vga_access,
  input  logic                  i_vga_cs,
  input  logic [ADDR_WIDTH-1:0] i_vga_addr,
  output logic [DATA_WIDTH-1:0] o_vga_dat,
  input  logic                  i_cpu_cs,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_dat,
  output logic [DATA_WIDTH-1:0] o_cpu_dat,
  output logic                  o_cpu_ack,
  output logic                  o_cpu_wait,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_dat,
  input  logic [DATA_WIDTH-1:0] i_ram_dat,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic                  o_vga_collision
);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  state_t state;
  logic   r_vga_own;
  logic   vga_active;
  logic   cpu_grant;

  // An unannounced VGA select still takes the cycle; it is only flagged.
  assign vga_active = r_vga_own | i_vga_cs;
  assign cpu_grant  = (state == S_IDLE) && i_cpu_cs && !vga_active;
  assign o_cpu_wait = (state == S_IDLE) && i_cpu_cs && vga_active;
  assign o_vga_dat  = i_ram_dat;

  always_comb begin
    o_ram_addr = '0;
    o_ram_dat  = '0;
    o_ram_cs   = 1'b0;
    o_ram_we   = 1'b0;
    if (vga_active) begin
      o_ram_addr = i_vga_addr;
      o_ram_cs   = i_vga_cs;
    end else if (cpu_grant) begin
      o_ram_addr = i_cpu_addr;
      o_ram_dat  = i_cpu_dat;
      o_ram_cs   = 1'b1;
      o_ram_we   = i_cpu_we;
    end
    // Keep RAM quiet while reset is held so no stray write lands.
    if (!i_reset_n) begin
      o_ram_cs = 1'b0;
      o_ram_we = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state           <= S_IDLE;
      o_cpu_ack       <= 1'b0;
      o_cpu_dat       <= '0;
      r_vga_own       <= 1'b0;
      o_vga_collision <= 1'b0;
    end else begin
      r_vga_own <= i_vga_access;
      if (i_vga_cs && !r_vga_own) begin
        o_vga_collision <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          o_cpu_ack <= 1'b0;
          if (cpu_grant) begin
            o_cpu_ack <= 1'b1;
            if (!i_cpu_we) begin
              o_cpu_dat <= i_ram_dat;
            end
            state <= S_ACK;
          end
        end
        S_ACK: begin
          o_cpu_ack <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vgaram_arbiter.sv
// Scoreboard bench for vgaram_arbiter: directed protocol scenarios followed by
// randomized CPU traffic interleaved with well-behaved random VGA fetches.
module tb_vgaram_arbiter;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vga_access = 1'b0;
  logic          vga_cs = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic [DW-1:0] vga_dat;
  logic          cpu_cs = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdat = '0;
  logic [DW-1:0] cpu_rdat;
  logic          cpu_ack;
  logic          cpu_wait;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdat;
  logic [DW-1:0] ram_rdat;
  logic          ram_cs;
  logic          ram_we;
  logic          collision;

  logic [DW-1:0] mem     [0:65535];
  logic [DW-1:0] ref_mem [0:65535];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;
  int            n_cmp = 0;
  int            n_mis = 0;
  bit            vga_chk = 1'b0;
  bit            cpu_done = 1'b0;

  always #5 clk = ~clk;

  vgaram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_vga_access   (vga_access),
    .i_vga_cs       (vga_cs),
    .i_vga_addr     (vga_addr),
    .o_vga_dat      (vga_dat),
    .i_cpu_cs       (cpu_cs),
    .i_cpu_we       (cpu_we),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_dat      (cpu_wdat),
    .o_cpu_dat      (cpu_rdat),
    .o_cpu_ack      (cpu_ack),
    .o_cpu_wait     (cpu_wait),
    .o_ram_addr     (ram_addr),
    .o_ram_dat      (ram_wdat),
    .i_ram_dat      (ram_rdat),
    .o_ram_cs       (ram_cs),
    .o_ram_we       (ram_we),
    .o_vga_collision(collision)
  );

  function automatic logic [DW-1:0] pattern(input int unsigned a);
    return 8'(a ^ (a >> 8) ^ 32'h5A);
  endfunction

  // Bench-side RAM: combinational read, write on the clock edge.
  assign ram_rdat = mem[ram_addr];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = pattern(i);
    mem[16'h1000] = 8'h41;
    mem[16'h0410] = 8'h3C;
    forever begin
      @(posedge clk);
      if (ram_cs && ram_we) mem[ram_addr] <= ram_wdat;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one expected read-data entry.
  always @(negedge clk) begin
    if (cpu_ack) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL spurious_ack: got ack=1 with no request outstanding, expected 0");
      end else begin
        check("cpu_rdata", 32'(cpu_rdat), 32'(exp_q.pop_front()));
      end
    end
    if (vga_chk && vga_cs) begin
      check("vga_dat", 32'(vga_dat), 32'(ref_mem[vga_addr]));
      check("vga_ram_addr", 32'(ram_addr), 32'(vga_addr));
      check("vga_ram_we", 32'(ram_we), 32'(0));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis + 1);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one CPU access, predict its ack data, wait (bounded) for the ack.
  task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int lat);
    if (we) begin
      exp_q.push_back(last_rd);
      ref_mem[a] = d;
    end else begin
      exp_q.push_back(ref_mem[a]);
      last_rd = ref_mem[a];
    end
    cpu_cs = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdat = d;
    lat = 0;
    @(negedge clk);
    while (!cpu_ack && lat < 64) begin
      lat++;
      @(negedge clk);
    end
    if (!cpu_ack) begin
      n_cmp++;
      n_mis++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack", lat);
    end
    tick();
    cpu_cs = 1'b0;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pattern(i);
    ref_mem[16'h1000] = 8'h41;
    ref_mem[16'h0410] = 8'h3C;

    // Reset held with a CPU write pending: RAM must stay deselected.
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0001; cpu_wdat = 8'hFF;
    repeat (2) begin
      @(negedge clk);
      check("rst_ram_cs", 32'(ram_cs), 32'(0));
      check("rst_ram_we", 32'(ram_we), 32'(0));
    end
    tick();
    rst_n = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(cpu_ack), 32'(0));
    check("rst_collision", 32'(collision), 32'(0));
    check("rst_cpu_dat", 32'(cpu_rdat), 32'(0));
    check("idle_ram_addr", 32'(ram_addr), 32'(0));
    check("idle_ram_cs", 32'(ram_cs), 32'(0));
    tick();

    // Write then read with VGA silent; minimum latency is one cycle.
    cpu_access(1'b1, 16'h1234, 8'hA5, lat);
    check("wr_latency", 32'(lat), 32'(1));
    cpu_access(1'b0, 16'h1234, 8'h00, lat);
    check("rd_latency", 32'(lat), 32'(1));
    cpu_access(1'b0, 16'h0001, 8'h00, lat);
    check("rd_after_reset_latency", 32'(lat), 32'(1));

    // Reservation: access at t and t+1, CPU read at t+1 waits two cycles.
    vga_access = 1'b1;
    tick();
    vga_cs = 1'b1; vga_addr = 16'h1000;
    exp_q.push_back(ref_mem[16'h1234]);
    last_rd = ref_mem[16'h1234];
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1234;
    @(negedge clk);
    check("resv_wait_t1", 32'(cpu_wait), 32'(1));
    check("resv_addr_t1", 32'(ram_addr), 32'h1000);
    check("resv_vga_dat_t1", 32'(vga_dat), 32'h41);
    tick();
    vga_access = 1'b0; vga_addr = 16'h0410;
    @(negedge clk);
    check("resv_wait_t2", 32'(cpu_wait), 32'(1));
    check("resv_addr_t2", 32'(ram_addr), 32'h0410);
    check("resv_vga_dat_t2", 32'(vga_dat), 32'h3C);
    check("resv_we_t2", 32'(ram_we), 32'(0));
    tick();
    vga_cs = 1'b0; vga_addr = '0;
    @(negedge clk);
    check("resv_wait_t3", 32'(cpu_wait), 32'(0));
    check("resv_grant_addr", 32'(ram_addr), 32'h1234);
    check("resv_grant_cs", 32'(ram_cs), 32'(1));
    check("resv_ack_t3", 32'(cpu_ack), 32'(0));
    tick();
    @(negedge clk);
    check("resv_ack_t4", 32'(cpu_ack), 32'(1));
    tick();
    cpu_cs = 1'b0;
    check("resv_collision", 32'(collision), 32'(0));

    // Unannounced VGA select: still wins the bus, sets the sticky flag.
    vga_cs = 1'b1; vga_addr = 16'h2222;
    @(negedge clk);
    check("coll_addr", 32'(ram_addr), 32'h2222);
    check("coll_before", 32'(collision), 32'(0));
    tick();
    vga_cs = 1'b0; vga_addr = '0;
    @(negedge clk);
    check("coll_set", 32'(collision), 32'(1));
    repeat (3) tick();
    @(negedge clk);
    check("coll_sticky", 32'(collision), 32'(1));

    // Reset while a CPU read is waiting behind VGA: request is dropped.
    tick();
    vga_access = 1'b1;
    tick();
    vga_cs = 1'b1; vga_addr = 16'h1000;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
    @(negedge clk);
    check("midrst_wait", 32'(cpu_wait), 32'(1));
    tick();
    rst_n = 1'b0; vga_access = 1'b0; vga_cs = 1'b0;
    @(negedge clk);
    check("midrst_ram_cs", 32'(ram_cs), 32'(0));
    tick();
    rst_n = 1'b1; cpu_cs = 1'b0;
    last_rd = '0;
    @(negedge clk);
    check("midrst_no_ack", 32'(cpu_ack), 32'(0));
    check("midrst_coll_clr", 32'(collision), 32'(0));
    tick();
    cpu_access(1'b0, 16'h0005, 8'h00, lat);
    check("midrst_reissue_latency", 32'(lat), 32'(1));

    // Random CPU traffic in the low region, random VGA fetches in the high region.
    vga_chk = 1'b1;
    fork
      begin : vga_gen
        bit prev = 1'b0;
        while (!cpu_done) begin
          tick();
          vga_cs = prev;
          vga_addr = prev ? (16'h8000 | 16'($urandom_range(0, 32767))) : '0;
          prev = ($urandom_range(0, 3) == 0);
          vga_access = prev;
        end
        tick();
        vga_cs = prev;
        vga_access = 1'b0;
        tick();
        vga_cs = 1'b0;
      end
      begin : cpu_gen
        int rlat;
        for (int n = 0; n < 80; n++) begin
          cpu_access(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)),
                     8'($urandom_range(0, 255)), rlat);
          repeat ($urandom_range(0, 2)) tick();
        end
        cpu_done = 1'b1;
      end
    join
    vga_chk = 1'b0;

    repeat (3) tick();
    check("rand_no_collision", 32'(collision), 32'(0));
    check("pending_expect", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/vgaram_arbiter.md
Name: vgaram_arbiter

Overview:
- Responder side of the VGA memory-access protocol; sits between the text-mode VGA fetch unit, the CPU, and the single shared video/system RAM.
- VGA announces each access one cycle ahead via its access line. The arbiter reserves the RAM for VGA in that next cycle.
- CPU accesses are scheduled into the remaining free cycles with a request/acknowledge handshake.
- The RAM has combinational read (data valid in the same cycle as the address) and writes on the clock edge.

Parameters:
- ADDR_WIDTH, 16, RAM address width for both masters.
- DATA_WIDTH, 8, RAM data width.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  synchronous reset, active-low
- i_vga_access  in  1  VGA requests the RAM in the next cycle
- i_vga_cs  in  1  VGA access active this cycle
- i_vga_addr  in  ADDR_WIDTH  VGA address
- o_vga_dat  out  DATA_WIDTH  read data to VGA, same cycle
- i_cpu_cs  in  1  CPU request; held until o_cpu_ack
- i_cpu_we  in  1  CPU write (1) / read (0), held with i_cpu_cs
- i_cpu_addr  in  ADDR_WIDTH  CPU address, held with i_cpu_cs
- i_cpu_dat  in  DATA_WIDTH  CPU write data, held with i_cpu_cs
- o_cpu_dat  out  DATA_WIDTH  registered CPU read data, valid while o_cpu_ack=1
- o_cpu_ack  out  1  one-cycle completion pulse
- o_cpu_wait  out  1  CPU request pending but blocked this cycle
- o_ram_addr  out  ADDR_WIDTH  RAM address
- o_ram_dat  out  DATA_WIDTH  RAM write data
- i_ram_dat  in  DATA_WIDTH  RAM read data, combinational
- o_ram_cs  out  1  RAM select
- o_ram_we  out  1  RAM write enable, sampled at clock edge
- o_vga_collision  out  1  sticky protocol-violation flag

Behaviour:
- Reservation register r_vga_own <= i_vga_access every cycle; r_vga_own=1 means VGA owns the RAM in that cycle.
- VGA path:
  - When r_vga_own || i_vga_cs: o_ram_addr=i_vga_addr, o_ram_cs=i_vga_cs, o_ram_we=0.
  - VGA is never stalled. o_vga_dat=i_ram_dat always (combinational).
- Collision: i_vga_cs=1 while r_vga_own=0 sets o_vga_collision=1. VGA still wins the cycle. The flag clears only on reset.
- CPU FSM, states IDLE and ACK:
  - IDLE, i_cpu_cs=1, r_vga_own=0, i_vga_cs=0: grant the CPU this cycle. o_ram_addr=i_cpu_addr, o_ram_dat=i_cpu_dat, o_ram_cs=1, o_ram_we=i_cpu_we. At the edge: o_cpu_dat<=i_ram_dat (reads only; unchanged on writes), o_cpu_ack<=1, go to ACK.
  - IDLE, i_cpu_cs=1, but VGA owns the cycle: o_cpu_wait=1, stay in IDLE, no RAM side effects from the CPU.
  - ACK: o_cpu_ack=1 for exactly this cycle. No CPU grant in this cycle (bubble), even if i_cpu_cs is still high. Always go to IDLE next.
- Timing: minimum CPU latency is request cycle → ack in the next cycle. Back-to-back CPU accesses are every 2 cycles.
- o_cpu_wait = state==IDLE && i_cpu_cs && (r_vga_own || i_vga_cs).
- Idle bus (no owner): o_ram_cs=0, o_ram_we=0, o_ram_addr=0, o_ram_dat=0.
- Reset (i_reset_n=0 at an edge):
  - Next state: IDLE, o_cpu_ack=0, o_cpu_dat=0, r_vga_own=0, o_vga_collision=0.
  - While i_reset_n=0: o_ram_cs=0 and o_ram_we=0 forced combinationally, so no RAM write can occur during the reset cycle.
  - A CPU request in flight at reset is dropped, not acked. The CPU must re-issue it.
- Simultaneous events:
  - i_vga_access=1 in the CPU grant cycle does not affect that grant; it only reserves the next cycle.
  - A CPU request arriving in the same cycle VGA owns waits until the first free IDLE cycle.
- No starvation guarantee is required: VGA uses at most 2 of every 8 pixel clocks in visible area.

Test Plan:
- Reset: hold i_reset_n=0 for 2 cycles with i_cpu_cs=1, i_cpu_we=1 → o_ram_we=0 and o_ram_cs=0 throughout; o_cpu_ack=0, o_vga_collision=0 after release.
- CPU write then read, VGA silent: write 0xA5 to 0x1234 → ack one cycle later. Read 0x1234 two cycles after that → o_cpu_dat=0xA5 with o_cpu_ack=1, exactly one ack per request.
- VGA reservation: i_vga_access=1 at cycles t and t+1; CPU read request at t+1 → o_cpu_wait=1 at t+1 and t+2, CPU granted at t+3, ack at t+4; VGA addresses on o_ram_addr at t+1 and t+2.
- VGA read path: RAM preloaded 0x1000=0x41, 0x0410=0x3C; VGA cs at 0x1000 then 0x0410 in consecutive owned cycles → o_vga_dat=0x41 then 0x3C in those same cycles.
- Collision: i_vga_cs=1 without preceding i_vga_access → o_vga_collision=1 and stays 1; VGA address still drives o_ram_addr.
- Reset mid-request: CPU read pending behind a VGA reservation; assert i_reset_n=0 → no ack ever issued for it; after release, a re-issued request acks normally in 1 cycle.
